pwm_ramp_ctrl: RTL
==================

PWM_RAMP_CTRL -- requirements
Module: pwm_ramp_ctrl

Interface
REQ-001 Parameter R: default 10; duty resolution, duty words are R+1 bits (0 = 0 %, 2^R = 100 %), matching the PWM core duty input.
REQ-002 Parameter RW: default 16; width of the rate (prescale) field.
REQ-003 i_clk  input  1  single clock; all state changes on rising edge.
REQ-004 i_rst  input  1  reset, synchronous, active-high.
REQ-005 i_cmd_valid  input  1  ramp command offered.
REQ-006 o_cmd_ready  output  1  controller can accept a command.
REQ-007 i_cmd_target  input  R+1  final duty of the ramp.
REQ-008 i_cmd_step  input  R+1  duty increment/decrement per step.
REQ-009 i_cmd_rate  input  RW  idle cycles between steps (step every rate+1 RAMP cycles).
REQ-010 i_abort  input  1  freeze duty at current value and end ramp.
REQ-011 o_duty  output  R+1  registered duty word driving the PWM core.
REQ-012 o_busy  output  1  high while in RAMP.
REQ-013 o_done  output  1  one-cycle pulse when ramp reaches target.

Function
REQ-014 FSM states IDLE and RAMP only; o_busy = (state == RAMP).
REQ-015 o_cmd_ready = (state == IDLE) and not i_abort and not i_rst; accept = i_cmd_valid and o_cmd_ready.
REQ-016 On accept the block latches target (clamped to 2^R if larger), step (0 replaced by 1) and rate; rate counter cleared to 0.
REQ-017 On accept with latched target != o_duty: next state RAMP; o_duty unchanged.
REQ-018 On accept with latched target == o_duty: state stays IDLE; o_done = 1 in the next cycle only.
REQ-019 In RAMP each cycle: if counter != rate, counter increments; if counter == rate, counter clears and one step is applied.
REQ-020 Step up (target > o_duty): o_duty <= min(o_duty + step, target); computed in R+2 bits, no overflow.
REQ-021 Step down (target < o_duty): o_duty <= max(o_duty - step, target); no underflow below target or 0.
REQ-022 When a step makes o_duty equal target: state -> IDLE and o_done = 1 in the same cycle o_duty first shows target.
REQ-023 rate = 0: one step per RAMP cycle; first o_duty change visible rate+1 cycles after entering RAMP.
REQ-024 i_cmd_valid in RAMP is ignored (ready low); command must be held by source until accepted.
REQ-025 i_abort in RAMP: next state IDLE, o_duty holds its current value, counter cleared, no o_done; abort wins over a step due the same cycle.
REQ-026 i_abort in IDLE: no effect other than blocking acceptance that cycle.
REQ-027 o_done is 0 in every cycle not named in REQ-018/REQ-022; never high together with o_busy.
REQ-028 Direction is fixed at accept time; o_duty is monotonic within one ramp.

Reset
REQ-029 While i_rst is high at a clock edge: state IDLE, o_duty = 0, counter = 0, latched fields = 0, o_done = 0, o_busy = 0; o_cmd_ready = 0 while i_rst high.
REQ-030 Reset mid-ramp aborts immediately; o_duty returns to 0, no o_done; first command accepted the cycle after i_rst falls.

Verification
REQ-031 R=10, o_duty 0, cmd target 100 step 30 rate 2 -> o_duty 30, 60, 90, 100 at 3-cycle intervals; o_done with 100; o_busy low after.
REQ-032 o_duty 100, cmd target 0 step 40 rate 0 -> o_duty 60, 20, 0 on consecutive cycles; o_done with 0.
REQ-033 Cmd target 2047 step 1024 rate 0 from 0 -> o_duty 1024 after one step, o_done; never exceeds 1024; step 0 target 3 -> 1, 2, 3.
REQ-034 Cmd target equal to o_duty (e.g. 0 after reset) -> no RAMP, o_busy never high, single o_done next cycle.
REQ-035 Ramp 0->500 step 10 rate 0, i_abort at o_duty 50 -> o_duty stays 50, IDLE, no o_done; valid held during RAMP accepted only after abort.
REQ-036 Ramp 0->500, i_rst pulsed at o_duty 200 -> o_duty 0, IDLE, ready low during reset, new command accepted the cycle after release.

Source files
------------

// File: rtl/pwm_ramp_ctrl.sv
// ============================================================================
//  pwm_ramp_ctrl -- slews a PWM duty word toward a commanded target in
//  fixed-size steps at a programmable rate.  Rev 1.0
// ============================================================================
`default_nettype none

module pwm_ramp_ctrl #(
  parameter int R  = 10,
  parameter int RW = 16
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_cmd_valid,
  output logic          o_cmd_ready,
  input  logic [R:0]    i_cmd_target,
  input  logic [R:0]    i_cmd_step,
  input  logic [RW-1:0] i_cmd_rate,
  input  logic          i_abort,
  output logic [R:0]    o_duty,
  output logic          o_busy,
  output logic          o_done
);

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_RAMP = 1'b1
  } state_t;

  localparam logic [R:0] c_FULL = {1'b1, {R{1'b0}}};

  state_t        state_q, state_d;
  logic [R:0]    duty_q, duty_d;
  logic [R:0]    target_q, target_d;
  logic [R:0]    step_q, step_d;
  logic [RW-1:0] rate_q, rate_d;
  logic [RW-1:0] cnt_q, cnt_d;
  logic          done_q, done_d;

  logic          w_accept;
  logic [R:0]    w_tgt_clamp;
  logic [R+1:0]  w_sum;
  logic [R+1:0]  w_diff;
  logic [R:0]    w_next;

  assign o_cmd_ready = (state_q == S_IDLE) && !i_abort && !i_rst;
  assign w_accept    = i_cmd_valid && o_cmd_ready;
  assign w_tgt_clamp = (i_cmd_target > c_FULL) ? c_FULL : i_cmd_target;

  // One extra bit absorbs both the overflow of the sum and the borrow of the difference.
  assign w_sum  = {1'b0, duty_q} + {1'b0, step_q};
  assign w_diff = {1'b0, duty_q} - {1'b0, step_q};

  always_comb begin
    w_next = duty_q;
    if (target_q > duty_q) begin
      w_next = (w_sum > {1'b0, target_q}) ? target_q : w_sum[R:0];
    end else begin
      w_next = (w_diff[R+1] || (w_diff[R:0] < target_q)) ? target_q : w_diff[R:0];
    end
  end

  always_comb begin
    state_d  = state_q;
    duty_d   = duty_q;
    target_d = target_q;
    step_d   = step_q;
    rate_d   = rate_q;
    cnt_d    = cnt_q;
    done_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (w_accept) begin
          target_d = w_tgt_clamp;
          step_d   = (i_cmd_step == '0) ? {{R{1'b0}}, 1'b1} : i_cmd_step;
          rate_d   = i_cmd_rate;
          cnt_d    = '0;
          if (w_tgt_clamp != duty_q) begin
            state_d = S_RAMP;
          end else begin
            done_d = 1'b1;
          end
        end
      end
      S_RAMP: begin
        // Abort takes priority over any step falling due this cycle.
        if (i_abort) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end else if (cnt_q != rate_q) begin
          cnt_d = cnt_q + 1'b1;
        end else begin
          cnt_d  = '0;
          duty_d = w_next;
          if (w_next == target_q) begin
            state_d = S_IDLE;
            done_d  = 1'b1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q  <= S_IDLE;
      duty_q   <= '0;
      target_q <= '0;
      step_q   <= '0;
      rate_q   <= '0;
      cnt_q    <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      duty_q   <= duty_d;
      target_q <= target_d;
      step_q   <= step_d;
      rate_q   <= rate_d;
      cnt_q    <= cnt_d;
      done_q   <= done_d;
    end
  end

  assign o_duty = duty_q;
  assign o_busy = (state_q == S_RAMP);
  assign o_done = done_q;

endmodule

`default_nettype wire
